uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Asynchronous serial transmitter; counterpart of the UART RX path. Frame: 8 data bits LSB first, no parity, `StopBits` stop bits.
- Accepts bytes over a valid/ready handshake into a one-deep holding register, then serialises them on TxD.
- Successive frames go out back-to-back with no idle gap. Drives the board UART TX pin; the FFT host link uses it to return results.

Parameters:
- ClkFrequency, 50000000: clk frequency in Hz.
- Baud, 115200: line rate in bit/s.
- StopBits, 1: stop bit count, 1 or 2; any other value is an elaboration error.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- tx_valid  input  1  tx_data is valid.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_ready  output  1  holding register empty; byte can be accepted.
- TxD  output  1  serial line, idle high, registered.
- tx_busy  output  1  a frame is on the line or the holding register is full.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: TxD=1, tx_busy=0, holding register empty (tx_ready=1), FSM=IDLE, tick accumulator=0.
- Reset mid-frame: TxD returns to 1 on the next edge. The current frame and any held byte are discarded.
- Baud tick (sub-module):
  - 32-bit accumulator, `acc += Baud` each clk while enabled.
  - When acc+Baud >= ClkFrequency: tick=1 and acc <= acc+Baud-ClkFrequency.
  - Gives exact average rate, jitter under one clk.
  - Enable = FSM not IDLE. acc is cleared in IDLE, so the first bit is full-length.
  - ClkFrequency < Baud*2 is an elaboration error.
- Handshake:
  - Transfer occurs when tx_valid && tx_ready at a clk edge. tx_data is latched into hold and hold_full is set.
  - tx_ready = !hold_full. No combinational path from tx_valid.
  - A hold drained and a new byte offered in the same cycle: that cycle is not ready; the byte is accepted next cycle.
- FSM states:
  - IDLE: TxD=1. If hold_full, load shifter from hold, clear hold_full, set TxD=0, go to START.
  - START: on tick, TxD=shift[0], bit count=0, go to DATA.
  - DATA: on each tick, shift right and drive the next bit. After bit 7's tick, TxD=1 and go to STOP.
  - STOP: hold TxD=1 for StopBits ticks. On the last tick:
    - if hold_full, reload, TxD=0, go to START (no idle cycle, tick phase continues);
    - else go to IDLE.
- Latency: handshake edge E0 → start bit driven from edge E0+2 (hold register, then FSM load).
- Frame length: (10 + StopBits - 1) bit periods. Each bit period is ClkFrequency/Baud clks on average.
- tx_busy = (state != IDLE) || hold_full, registered.
- tx_data changing while a frame is in flight has no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Drives even parity (XOR of the 8 data bits) for one bit period.
  - Frame grows by one bit.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame is exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding enum (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_W=8;
  - the baud accumulator width constant (32).
- Sub-module uart_baud_tick (ports: clk, rst, enable, tick; parameters ClkFrequency, Baud), reusable by the RX side.

Test Plan (all with ClkFrequency=1000000, Baud=100000 → 10 clks/bit):
- Single byte 0xA5 → TxD low 2 clks after handshake. TxD sequence 0,1,0,1,0,0,1,0,1,1, each 10 clks. tx_busy high for 100 clks, then TxD=1 and tx_ready=1.
- Back-to-back 0x00 then 0xFF, second offered while the first is shifting:
  - second accepted while the first is still shifting (tx_ready=0 until accepted);
  - second start bit immediately follows the first stop bit; no idle clk, 200 clks total.
- tx_valid held high with 3 bytes 0x01,0x02,0x03 → exactly 3 frames in order. tx_ready pulses once per frame.
- rst asserted at clk 45 of a frame → TxD=1, tx_busy=0, tx_ready=1 after the next edge. Next byte 0x3C transmits correctly.
- StopBits=2, byte 0x80 → stop high for 20 clks. Next frame starts at clk 110 after the first start bit.
- With UART_TX_PARITY_EN defined:
  - 0xA5 → parity bit 0 after bit 7, frame 110 clks;
  - 0x07 → parity bit 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, data width and baud accumulator width.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_ACC_W  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uartTxState_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud-rate tick generator: phase accumulator that steps by Baud each clk and
// wraps at ClkFrequency, giving an exact long-term rate with under one clk of jitter.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    generate
        if (ClkFrequency < Baud * 2) begin : gBadRatio
            $error("uart_baud_tick: ClkFrequency must be at least twice Baud");
        end
    endgenerate

    localparam logic [UART_ACC_W-1:0] BaudInc = UART_ACC_W'(Baud);
    localparam logic [UART_ACC_W-1:0] ClkFreq = UART_ACC_W'(ClkFrequency);

    logic [UART_ACC_W-1:0] acc;
    logic [UART_ACC_W-1:0] accSum;

    assign accSum = acc + BaudInc;
    assign tick   = enable && (accSum >= ClkFreq);

    // Held at zero while disabled so the first period after enable is full length.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            acc <= '0;
        end else if (tick) begin
            acc <= accSum - ClkFreq;
        end else begin
            acc <= accSum;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: one-deep holding register fed by valid/ready, frames sent back-to-back on TxD.
// Define UART_TX_PARITY_EN to append an even-parity bit between the data and stop bits.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int StopBits     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   TxD,
    output logic                   tx_busy
);

    generate
        if (StopBits != 1 && StopBits != 2) begin : gBadStopBits
            $error("uart_tx_framer: StopBits must be 1 or 2");
        end
    endgenerate

    localparam logic LastStop = 1'(StopBits - 1);
`ifdef UART_TX_PARITY_EN
    localparam uartTxState_e AfterData = PARITY;
`else
    localparam uartTxState_e AfterData = STOP;
`endif

    uartTxState_e state, stateNext;

    logic [UART_DATA_W-1:0] hold;
    logic [UART_DATA_W-1:0] shift;
    logic                   holdFull;
    logic [2:0]             bitCnt;
    logic                   stopCnt;
    logic                   tick;
    logic                   tickEn;
    logic                   accept;
    logic                   lastStopTick;
    logic                   load;
    logic                   txdNext;
`ifdef UART_TX_PARITY_EN
    logic                   parityBit;
`endif

    assign tickEn = (state != IDLE);

    uart_baud_tick #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud)
    ) uBaudTick (
        .clk   (clk),
        .rst   (rst),
        .enable(tickEn),
        .tick  (tick)
    );

    assign tx_ready     = !holdFull;
    assign accept       = tx_valid && !holdFull;
    assign lastStopTick = (state == STOP) && tick && (stopCnt == LastStop);
    // Shifter reloads from idle, or straight out of the last stop bit to avoid an idle gap.
    assign load         = holdFull && ((state == IDLE) || lastStopTick);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (holdFull) stateNext = START;
            START:  if (tick) stateNext = DATA;
            DATA:   if (tick && bitCnt == 3'd7) stateNext = AfterData;
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) stateNext = STOP;
`endif
            STOP:   if (lastStopTick) stateNext = holdFull ? START : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Line level is a function of the current state; TxD registers it one clk later.
    always_comb begin
        txdNext = 1'b1;
        case (state)
            START:  txdNext = 1'b0;
            DATA:   txdNext = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txdNext = parityBit;
`endif
            default: txdNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            holdFull <= 1'b0;
            shift    <= '0;
            bitCnt   <= '0;
            stopCnt  <= 1'b0;
            TxD      <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            TxD     <= txdNext;
            tx_busy <= (state != IDLE) || holdFull;

            if (accept) begin
                hold     <= tx_data;
                holdFull <= 1'b1;
            end else if (load) begin
                holdFull <= 1'b0;
            end

            if (load) begin
                shift   <= hold;
                bitCnt  <= '0;
                stopCnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parityBit <= ^hold;
`endif
            end else if (tick) begin
                if (state == DATA && bitCnt != 3'd7) begin
                    shift  <= shift >> 1;
                    bitCnt <= bitCnt + 3'd1;
                end
                if (state == STOP) begin
                    stopCnt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: directed bytes are queued on acceptance and a line
// monitor per DUT decodes TxD frames (10 clks/bit), checking bits, latency and gaps.
`timescale 1ns/1ps
module tb_uart_tx_framer;

    localparam int CLK_HZ   = 1000000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = 10;

    typedef struct {
        logic [7:0] data;
        int         acceptCyc;
        bit         chkLat;
        bit         b2b;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      txValid;
    logic [1:0][7:0] txData;
    logic [1:0]      txReady;
    logic [1:0]      txd;
    logic [1:0]      txBusy;
    bit   [1:0]      abortFlag;

    item_t q0[$];
    item_t q1[$];

    int cyc     = 0;
    int asserts = 0;
    int fails   = 0;
    int e0;
    bit ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_framer #(.ClkFrequency(CLK_HZ), .Baud(BAUD), .StopBits(1)) dut0 (
        .clk(clk), .rst(rst), .tx_valid(txValid[0]), .tx_data(txData[0]),
        .tx_ready(txReady[0]), .TxD(txd[0]), .tx_busy(txBusy[0]));

    uart_tx_framer #(.ClkFrequency(CLK_HZ), .Baud(BAUD), .StopBits(2)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(txValid[1]), .tx_data(txData[1]),
        .tx_ready(txReady[1]), .TxD(txd[1]), .tx_busy(txBusy[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input int which, input logic [7:0] d, input bit chkLat,
                        input bit b2b, input bit keep);
        item_t it;
        int n;
        n = 0;
        @(negedge clk);
        txValid[which] = 1'b1;
        txData[which]  = d;
        while (txReady[which] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk($sformatf("sendTimeout%0d", which), 32'(txReady[which]), 1);
            txValid[which] = 1'b0;
            return;
        end
        it.data = d; it.acceptCyc = cyc + 1; it.chkLat = chkLat; it.b2b = b2b;
        if (which == 0) q0.push_back(it); else q1.push_back(it);
        @(posedge clk);
        #1;
        if (!keep) txValid[which] = 1'b0;
    endtask

    task automatic waitIdle(input int which);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((n < 3 || txBusy[which] !== 1'b0 || txd[which] !== 1'b1 ||
                    (which == 0 ? q0.size() : q1.size()) != 0) && n < 5000);
        chk($sformatf("idleTimeout%0d", which), 32'(n < 5000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic monitor(input int which);
        item_t      it;
        logic [11:0] bits;
        int         nb, startCyc, prevEnd;
        bit         mism, aborted, have;
        prevEnd = -1000;
        forever begin
            @(negedge clk);
            if (txd[which] === 1'b0) begin
                startCyc = cyc;
                have = 1'b0;
                if (which == 0 && q0.size() > 0) begin it = q0.pop_front(); have = 1'b1; end
                else if (which == 1 && q1.size() > 0) begin it = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    chk($sformatf("unexpectedFrame%0d", which), 1, 0);
                    it.data = '0; it.acceptCyc = 0; it.chkLat = 1'b0; it.b2b = 1'b0;
                end
                bits      = '1;
                bits[0]   = 1'b0;
                bits[8:1] = it.data;
                nb        = 9;
`ifdef UART_TX_PARITY_EN
                bits[9]   = ^it.data;
                nb        = 10;
`endif
                nb = nb + ((which == 0) ? 1 : 2);
                if (it.chkLat) chk($sformatf("startLatency%0d_%02h", which, it.data), startCyc, it.acceptCyc + 2);
                if (it.b2b) chk($sformatf("noIdleGap%0d_%02h", which, it.data), startCyc, prevEnd + 1);
                aborted = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    mism = 1'b0;
                    for (int s = 0; s < BIT_CLKS; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (abortFlag[which]) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (txd[which] !== bits[b]) mism = 1'b1;
                    end
                    if (aborted) break;
                    chk($sformatf("frame%0d_%02h_bit%0d", which, it.data, b), 32'(mism), 0);
                end
                if (!aborted) prevEnd = cyc;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        txValid   = '0;
        txData    = '0;
        abortFlag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("resetTxD%0d", i), 32'(txd[i]), 1);
            chk($sformatf("resetBusy%0d", i), 32'(txBusy[i]), 0);
            chk($sformatf("resetReady%0d", i), 32'(txReady[i]), 1);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 0xA5: busy across the whole frame, idle line afterwards
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        e0 = cyc;
        repeat (2) @(negedge clk);
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (txBusy[0] !== 1'b1) ok = 1'b0;
        end
        chk("busyDuringFrame", 32'(ok), 1);
        @(negedge clk);
        chk("busyAfterFrame", 32'(txBusy[0]), 0);
        chk("txdAfterFrame", 32'(txd[0]), 1);
        chk("readyAfterFrame", 32'(txReady[0]), 1);
        chk("frameEndCycle", cyc, e0 + 102);
        waitIdle(0);

        // 0x00 then 0xFF offered mid-frame: held, then sent with no idle gap
        send(0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        send(0, 8'hFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("readyWhileHeld", 32'(txReady[0]), 0);
        waitIdle(0);

        // tx_valid held high across three bytes
        send(0, 8'h01, 1'b1, 1'b0, 1'b1);
        send(0, 8'h02, 1'b0, 1'b1, 1'b1);
        send(0, 8'h03, 1'b0, 1'b1, 1'b0);
        waitIdle(0);

        // Reset mid-frame with a byte waiting in hold: both are dropped
        send(0, 8'h96, 1'b1, 1'b0, 1'b0);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (45) @(negedge clk);
        abortFlag[0] = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midResetTxD", 32'(txd[0]), 1);
        chk("midResetBusy", 32'(txBusy[0]), 0);
        chk("midResetReady", 32'(txReady[0]), 1);
        q0.delete();
        @(negedge clk);
        abortFlag[0] = 1'b0;
        repeat (5) @(negedge clk);
        send(0, 8'h3C, 1'b1, 1'b0, 1'b0);
        waitIdle(0);

        // Odd parity-weight byte
        send(0, 8'h07, 1'b1, 1'b0, 1'b0);
        waitIdle(0);

        // Two stop bits: 0x80 then 0x4B back-to-back
        send(1, 8'h80, 1'b1, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        send(1, 8'h4B, 1'b0, 1'b1, 1'b0);
        waitIdle(1);

        chk("queue0Drained", q0.size(), 0);
        chk("queue1Drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
